// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS-style control unit: state
// encoding, opcode constants and the datapath mux/ALU selection codes.
package unidade_controle_multiciclo_pkg;

   // IDLE is pinned to 0 so the debug state output reads zero in reset.
   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      RWB    = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10,
      ADDIEX = 4'd11,
      ADDIWB = 4'd12
   } stateT;

   // Opcodes understood by the decoder.
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // ALU operation codes.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B operand select.
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PC source select.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: a Moore FSM that sequences fetch, decode and the
// per-instruction execute/memory/write-back steps, with memory wait states.
module unidade_controle_multiciclo
   import unidade_controle_multiciclo_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 2,
   parameter bit EN_ADDI  = 1'b1,
   parameter bit EN_BNE   = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                branch_ne,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          pc_source,
   output logic                illegal_op,
   output logic [3:0]          state_o
);

   stateT       state;
   stateT       nextState;
   logic        bneSel;
   logic [1:0]  aluOpSel;
   logic        isLw, isSw, isR, isBeq, isBne, isJ, isAddi;

   assign isLw   = (opcode == OPCODE_W'(OP_LW));
   assign isSw   = (opcode == OPCODE_W'(OP_SW));
   assign isR    = (opcode == OPCODE_W'(OP_R));
   assign isBeq  = (opcode == OPCODE_W'(OP_BEQ));
   assign isBne  = (opcode == OPCODE_W'(OP_BNE));
   assign isJ    = (opcode == OPCODE_W'(OP_J));
   assign isAddi = (opcode == OPCODE_W'(OP_ADDI));

   assign alu_op  = ALUOP_W'(aluOpSel);
   assign state_o = state;

   // State register; also remembers at DECODE whether the branch is a BNE,
   // so later opcode changes cannot alter branch_ne.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         bneSel <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update in step
         // with the same clock edge, regardless of statement order.
         state <= nextState;
         if (state == DECODE) begin
            bneSel <= EN_BNE && isBne;
         end
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      nextState     = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      aluOpSel      = ALU_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;

      case (state)
         IDLE: nextState = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               nextState = DECODE;
            end
         end
         DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            if (isLw || isSw)                  nextState = MEMADR;
            else if (isR)                      nextState = EXEC;
            else if (isBeq || (EN_BNE && isBne)) nextState = BRANCH;
            else if (isJ)                      nextState = JUMP;
            else if (EN_ADDI && isAddi)        nextState = ADDIEX;
            else begin
               nextState  = FETCH;
               illegal_op = 1'b1;
            end
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            nextState = isSw ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) nextState = MEMWB;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            nextState  = FETCH;
         end
         MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) nextState = FETCH;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            aluOpSel  = ALU_FUNCT;
            nextState = RWB;
         end
         RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            nextState = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            aluOpSel      = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            branch_ne     = bneSel;
            nextState     = FETCH;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            nextState = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            nextState = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            nextState = FETCH;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench for the multicycle control unit. Two instances: one with
// all optional opcodes enabled, one with ADDI and BNE disabled.
module tb_unidade_controle_multiciclo;
   import unidade_controle_multiciclo_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcodeA = 6'd0, opcodeB = 6'd0;
   logic       mrA = 1'b0, mrB = 1'b0;

   logic pwA, pwcA, bneA, iordA, mrdA, mwrA, irwA, m2rA, rdstA, rwA, asaA, illA;
   logic pwB, pwcB, bneB, iordB, mrdB, mwrB, irwB, m2rB, rdstB, rwB, asaB, illB;
   logic [1:0] asbA, aopA, psA, asbB, aopB, psB;
   logic [3:0] stateA, stateB;
   logic [17:0] outA, outB;

   int tests = 0;
   int failed = 0;

   typedef struct {
      bit         useB;
      logic [5:0] op;
      logic       mr;
      logic [3:0] st;
      logic [17:0] out;
   } entryT;

   entryT sb[$];

   always #5 clk = ~clk;

   unidade_controle_multiciclo dutA (
      .clk(clk), .rst_n(rst_n), .opcode(opcodeA), .mem_ready(mrA),
      .pc_write(pwA), .pc_write_cond(pwcA), .branch_ne(bneA), .iord(iordA),
      .mem_read(mrdA), .mem_write(mwrA), .ir_write(irwA), .mem_to_reg(m2rA),
      .reg_dst(rdstA), .reg_write(rwA), .alu_src_a(asaA), .alu_src_b(asbA),
      .alu_op(aopA), .pc_source(psA), .illegal_op(illA), .state_o(stateA)
   );

   unidade_controle_multiciclo #(.EN_ADDI(1'b0), .EN_BNE(1'b0)) dutB (
      .clk(clk), .rst_n(rst_n), .opcode(opcodeB), .mem_ready(mrB),
      .pc_write(pwB), .pc_write_cond(pwcB), .branch_ne(bneB), .iord(iordB),
      .mem_read(mrdB), .mem_write(mwrB), .ir_write(irwB), .mem_to_reg(m2rB),
      .reg_dst(rdstB), .reg_write(rwB), .alu_src_a(asaB), .alu_src_b(asbB),
      .alu_op(aopB), .pc_source(psB), .illegal_op(illB), .state_o(stateB)
   );

   // Output vector: bit 13 = mem_read, bit 12 = mem_write.
   assign outA = {pwA, pwcA, bneA, iordA, mrdA, mwrA, irwA, m2rA, rdstA, rwA,
                  asaA, asbA, aopA, psA, illA};
   assign outB = {pwB, pwcB, bneB, iordB, mrdB, mwrB, irwB, m2rB, rdstB, rwB,
                  asaB, asbB, aopB, psB, illB};

   // Expected outputs for one cycle, written from the state table.
   function automatic logic [17:0] expOut(input stateT s, input logic mr,
                                          input logic isBne, input logic ill);
      logic pw, pwc, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop, ps;
      {pw, pwc, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; ps = 2'b00;
      case (s)
         FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
         DECODE: asb = 2'b11;
         MEMADR: begin asa = 1'b1; asb = 2'b10; end
         MEMRD:  begin mrd = 1'b1; io = 1'b1; end
         MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
         MEMWR:  begin mwr = 1'b1; io = 1'b1; end
         EXEC:   begin asa = 1'b1; aop = 2'b10; end
         RWB:    begin rw = 1'b1; rdst = 1'b1; end
         BRANCH: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; bne = isBne; end
         JUMP:   begin pw = 1'b1; ps = 2'b10; end
         ADDIEX: begin asa = 1'b1; asb = 2'b10; end
         ADDIWB: rw = 1'b1;
         default: ;
      endcase
      return {pw, pwc, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ps,
              (s == DECODE) ? ill : 1'b0};
   endfunction

   function automatic logic [5:0] rndOp();
      return 6'($urandom);
   endfunction

   task automatic pushCycle(input bit useB, input stateT st, input logic [5:0] op,
                            input logic mr, input logic isBne, input logic ill);
      entryT e;
      e.useB = useB;
      e.op   = op;
      e.mr   = mr;
      e.st   = st;
      e.out  = expOut(st, mr, isBne, ill);
      sb.push_back(e);
   endtask

   // Push the full expected cycle sequence of one instruction starting in
   // FETCH. Opcode is only meaningful in DECODE/MEMADR; elsewhere it is junk.
   task automatic pushInstr(input bit useB, input logic [5:0] op, input int fw,
                            input int mw, input bit enAddi, input bit enBne);
      bit isBne, legal;
      isBne = (op == 6'b000101);
      legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
              (op == 6'b000100) || (op == 6'b000010) ||
              (isBne && enBne) || ((op == 6'b001000) && enAddi);
      for (int i = 0; i < fw; i++) pushCycle(useB, FETCH, rndOp(), 1'b0, 1'b0, 1'b0);
      pushCycle(useB, FETCH, rndOp(), 1'b1, 1'b0, 1'b0);
      pushCycle(useB, DECODE, op, 1'($urandom), 1'b0, !legal);
      if (!legal) return;
      case (op)
         6'b100011: begin
            pushCycle(useB, MEMADR, op, 1'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < mw; i++) pushCycle(useB, MEMRD, rndOp(), 1'b0, 1'b0, 1'b0);
            pushCycle(useB, MEMRD, rndOp(), 1'b1, 1'b0, 1'b0);
            pushCycle(useB, MEMWB, rndOp(), 1'($urandom), 1'b0, 1'b0);
         end
         6'b101011: begin
            pushCycle(useB, MEMADR, op, 1'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < mw; i++) pushCycle(useB, MEMWR, rndOp(), 1'b0, 1'b0, 1'b0);
            pushCycle(useB, MEMWR, rndOp(), 1'b1, 1'b0, 1'b0);
         end
         6'b000000: begin
            pushCycle(useB, EXEC, rndOp(), 1'($urandom), 1'b0, 1'b0);
            pushCycle(useB, RWB, rndOp(), 1'($urandom), 1'b0, 1'b0);
         end
         6'b000100, 6'b000101:
            pushCycle(useB, BRANCH, rndOp(), 1'($urandom), isBne, 1'b0);
         6'b000010:
            pushCycle(useB, JUMP, rndOp(), 1'($urandom), 1'b0, 1'b0);
         default: begin
            pushCycle(useB, ADDIEX, rndOp(), 1'($urandom), 1'b0, 1'b0);
            pushCycle(useB, ADDIWB, rndOp(), 1'($urandom), 1'b0, 1'b0);
         end
      endcase
   endtask

   // Pop up to maxN entries (all if maxN < 0): drive at the falling edge,
   // compare 1 time unit later, then let the rising edge advance the FSM.
   task automatic drain(input string name, input int maxN);
      entryT e;
      logic [3:0] st;
      logic [17:0] o;
      int n = 0;
      while (sb.size() > 0 && (maxN < 0 || n < maxN)) begin
         e = sb.pop_front();
         n++;
         if (e.useB) begin opcodeB = e.op; mrB = e.mr; mrA = 1'b0; end
         else        begin opcodeA = e.op; mrA = e.mr; mrB = 1'b0; end
         #1;
         st = e.useB ? stateB : stateA;
         o  = e.useB ? outB : outA;
         tests++;
         if (st !== e.st) begin
            failed++;
            $display("FAIL %s cycle %0d state: got %0d expected %0d", name, n, st, e.st);
         end
         tests++;
         if (o !== e.out) begin
            failed++;
            $display("FAIL %s cycle %0d outputs (state %0d): got %b expected %b",
                     name, n, e.st, o, e.out);
         end
         tests++;
         if (o[13] && o[12]) begin
            failed++;
            $display("FAIL %s cycle %0d mem_read/mem_write both high: got %b expected 0", name, n, o[13:12]);
         end
         @(negedge clk);
      end
   endtask

   task automatic checkAllZero(input string name);
      tests++;
      if (stateA !== 4'd0 || outA !== 18'd0) begin
         failed++;
         $display("FAIL %s dutA: got state %0d out %b expected state 0 out 0", name, stateA, outA);
      end
      tests++;
      if (stateB !== 4'd0 || outB !== 18'd0) begin
         failed++;
         $display("FAIL %s dutB: got state %0d out %b expected state 0 out 0", name, stateB, outB);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mrA = 1'b1; mrB = 1'b1; opcodeA = 6'b100011; opcodeB = 6'b111111;
      repeat (2) @(negedge clk);
      checkAllZero("reset_hold");
      rst_n = 1'b1;
      pushCycle(1'b0, IDLE, 6'b100011, 1'b1, 1'b0, 1'b0);
      pushInstr(1'b0, 6'b100011, 0, 0, 1'b1, 1'b1);
      drain("reset_then_lw", -1);
   endtask

   task automatic test_lw_waits();
      pushInstr(1'b0, 6'b100011, 2, 3, 1'b1, 1'b1);
      drain("lw_waits", -1);
   endtask

   task automatic test_sw_waits();
      pushInstr(1'b0, 6'b101011, 0, 3, 1'b1, 1'b1);
      drain("sw_waits", -1);
   endtask

   task automatic test_rtype();
      pushInstr(1'b0, 6'b000000, 0, 0, 1'b1, 1'b1);
      drain("rtype", -1);
   endtask

   task automatic test_branch();
      pushInstr(1'b0, 6'b000100, 0, 0, 1'b1, 1'b1);
      pushInstr(1'b0, 6'b000101, 1, 0, 1'b1, 1'b1);
      drain("branch", -1);
   endtask

   task automatic test_jump_addi_illegal();
      pushInstr(1'b0, 6'b000010, 0, 0, 1'b1, 1'b1);
      pushInstr(1'b0, 6'b001000, 0, 0, 1'b1, 1'b1);
      pushInstr(1'b0, 6'b111111, 0, 0, 1'b1, 1'b1);
      drain("jump_addi_illegal", -1);
   endtask

   task automatic test_disabled();
      pushInstr(1'b1, 6'b000101, 0, 0, 1'b0, 1'b0);
      pushInstr(1'b1, 6'b001000, 0, 0, 1'b0, 1'b0);
      pushInstr(1'b1, 6'b000100, 0, 0, 1'b0, 1'b0);
      pushInstr(1'b1, 6'b100011, 1, 1, 1'b0, 1'b0);
      drain("disabled_ops", -1);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [7];
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b001000};
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 7; i++)
            pushInstr(1'b0, ops[i], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'b1, 1'b1);
      drain("back_to_back", -1);
   endtask

   task automatic test_reset_mid();
      // Stop inside MEMRD while memory is still busy.
      pushInstr(1'b0, 6'b100011, 0, 5, 1'b1, 1'b1);
      drain("reset_mid_pre", 5);
      sb.delete();
      mrA = 1'b0;
      #2 rst_n = 1'b0;
      #1 checkAllZero("reset_mid_async");
      @(negedge clk);
      rst_n = 1'b1;
      pushCycle(1'b0, IDLE, rndOp(), 1'b0, 1'b0, 1'b0);
      pushInstr(1'b0, 6'b000000, 1, 0, 1'b1, 1'b1);
      drain("reset_mid_resume", -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lw_waits();
      test_sw_waits();
      test_rtype();
      test_branch();
      test_jump_addi_illegal();
      test_disabled();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
